// File: rtl/frame_swap_ctrl_if.sv
// Bundle of the CPU write port, swap control and back-buffer write bus of frame_swap_ctrl.
interface frame_swap_ctrl_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_wr_req;
  logic [ADDR_W-1:0] cpu_wr_addr;
  logic [DATA_W-1:0] cpu_wr_data;
  logic              cpu_wr_ack;
  logic              swap_req;
  logic              clear_on_swap;
  logic              vblank_start;
  logic              swap_busy;
  logic              swap_done;
  logic              front_sel;
  logic              buf_en;
  logic              switch_buffer;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic [15:0]       frame_count;

  modport master (
    output cpu_wr_req, cpu_wr_addr, cpu_wr_data, swap_req, clear_on_swap, vblank_start,
    input  cpu_wr_ack, swap_busy, swap_done, front_sel, buf_en, switch_buffer,
           wr_addr, wr_data, wr_en, frame_count
  );

  modport slave (
    input  cpu_wr_req, cpu_wr_addr, cpu_wr_data, swap_req, clear_on_swap, vblank_start,
    output cpu_wr_ack, swap_busy, swap_done, front_sel, buf_en, switch_buffer,
           wr_addr, wr_data, wr_en, frame_count
  );
endinterface

// File: rtl/frame_swap_ctrl.sv
// Double-buffer sequencer for the VGA text path: forwards CPU writes to the back buffer,
// switches buffers at vblank on request and optionally refills the new back buffer.
module frame_swap_ctrl #(
  parameter int unsigned      ADDR_W     = 13,
  parameter int unsigned      DATA_W     = 32,
  parameter int unsigned      DEPTH      = 4800,
  parameter logic [DATA_W-1:0] CLEAR_WORD = 32'h0000_0020,
  parameter int unsigned      SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  frame_swap_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VB = 3'd1,
    SWAP    = 3'd2,
    SETTLE  = 3'd3,
    CLEAR   = 3'd4
  } state_e;

  localparam int unsigned       SET_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYC - 1);

  state_e              state_q, state_d;
  logic [SET_W-1:0]    set_cnt_q, set_cnt_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                clr_flag_q, clr_flag_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                front_q, front_d;
  logic                buf_en_q, buf_en_d;
  logic                switch_q, switch_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic                cpu_take_c;

  // Next-state and next-output logic; strobes default low every cycle.
  always_comb begin
    state_d       = state_q;
    set_cnt_d     = set_cnt_q;
    clr_cnt_d     = clr_cnt_q;
    clr_flag_d    = clr_flag_q;
    ack_d         = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    front_d       = front_q;
    buf_en_d      = 1'b1;
    switch_d      = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    wr_en_d       = 1'b0;
    frame_count_d = frame_count_q;
    cpu_take_c    = 1'b0;

    case (state_q)
      IDLE: begin
        cpu_take_c = 1'b1;
        if (bus.swap_req) begin
          state_d    = WAIT_VB;
          clr_flag_d = bus.clear_on_swap;
          busy_d     = 1'b1;
        end
      end
      WAIT_VB: begin
        if (bus.vblank_start) begin
          state_d  = SWAP;
          switch_d = 1'b1;
        end else begin
          cpu_take_c = 1'b1;
        end
      end
      SWAP: begin
        front_d       = ~front_q;
        frame_count_d = frame_count_q + 16'd1;
        set_cnt_d     = '0;
        state_d       = SETTLE;
      end
      SETTLE: begin
        if (set_cnt_q == SET_LAST) begin
          if (clr_flag_q) begin
            // First clear word is launched here so it lands on the first CLEAR cycle.
            state_d   = CLEAR;
            clr_cnt_d = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = CLEAR_WORD;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          set_cnt_d = set_cnt_q + SET_W'(1);
        end
      end
      CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          clr_flag_d = 1'b0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          wr_en_d   = 1'b1;
          wr_addr_d = clr_cnt_q + ADDR_W'(1);
          wr_data_d = CLEAR_WORD;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Out-of-range CPU addresses are acknowledged but never strobed.
    if (cpu_take_c && bus.cpu_wr_req) begin
      ack_d     = 1'b1;
      wr_addr_d = bus.cpu_wr_addr;
      wr_data_d = bus.cpu_wr_data;
      wr_en_d   = (bus.cpu_wr_addr <= LAST_ADDR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      set_cnt_q     <= '0;
      clr_cnt_q     <= '0;
      clr_flag_q    <= 1'b0;
      ack_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      front_q       <= 1'b0;
      buf_en_q      <= 1'b0;
      switch_q      <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_en_q       <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      set_cnt_q     <= set_cnt_d;
      clr_cnt_q     <= clr_cnt_d;
      clr_flag_q    <= clr_flag_d;
      ack_q         <= ack_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      front_q       <= front_d;
      buf_en_q      <= buf_en_d;
      switch_q      <= switch_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_en_q       <= wr_en_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign bus.cpu_wr_ack    = ack_q;
  assign bus.swap_busy     = busy_q;
  assign bus.swap_done     = done_q;
  assign bus.front_sel     = front_q;
  assign bus.buf_en        = buf_en_q;
  assign bus.switch_buffer = switch_q;
  assign bus.wr_addr       = wr_addr_q;
  assign bus.wr_data       = wr_data_q;
  assign bus.wr_en         = wr_en_q;
  assign bus.frame_count   = frame_count_q;

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Scenario bench for frame_swap_ctrl; expectations come from the swap latency rules and a
// simple frame/front model kept here.
module tb_frame_swap_ctrl;
  localparam int unsigned ADDR_W     = 13;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned DEPTH      = 4800;
  localparam int unsigned SETTLE_CYC = 2;
  localparam logic [31:0] CLEAR_WORD = 32'h0000_0020;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  // Model: displayed buffer and completed-swap count.
  logic        exp_front = 1'b0;
  logic [15:0] exp_count = 16'd0;

  frame_swap_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  frame_swap_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .CLEAR_WORD(CLEAR_WORD), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_wr_req    = 1'b0;
    bus.cpu_wr_addr   = '0;
    bus.cpu_wr_data   = '0;
    bus.swap_req      = 1'b0;
    bus.clear_on_swap = 1'b0;
    bus.vblank_start  = 1'b0;
  endtask

  function automatic logic [67:0] outs_vec();
    return {bus.cpu_wr_ack, bus.swap_busy, bus.swap_done, bus.front_sel, bus.buf_en,
            bus.switch_buffer, bus.wr_addr, bus.wr_data, bus.wr_en, bus.frame_count};
  endfunction

  task automatic test_reset();
    rst               = 1'b1;
    bus.cpu_wr_req    = 1'b1;
    bus.cpu_wr_addr   = 13'd5;
    bus.cpu_wr_data   = $urandom;
    bus.swap_req      = 1'b1;
    bus.clear_on_swap = 1'b1;
    bus.vblank_start  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if (outs_vec() !== 68'd0) begin
        n_err++;
        $display("FAIL reset_outs cyc%0d: got %h required 0", i, outs_vec());
      end
    end
    rst = 1'b0;
    idle_inputs();
    cyc();
    n_cmp++;
    if (bus.buf_en !== 1'b1) begin
      n_err++;
      $display("FAIL reset_buf_en: got %b required 1", bus.buf_en);
    end
    n_cmp++;
    if ({bus.cpu_wr_ack, bus.swap_busy, bus.swap_done, bus.front_sel, bus.switch_buffer,
         bus.wr_en, bus.frame_count} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_release_outs: got %h required 0", outs_vec());
    end
    exp_front = 1'b0;
    exp_count = 16'd0;
  endtask

  task automatic test_write();
    bus.cpu_wr_req  = 1'b1;
    bus.cpu_wr_addr = 13'd5;
    bus.cpu_wr_data = 32'h41;
    cyc();
    n_cmp++;
    if (bus.cpu_wr_ack !== 1'b1) begin n_err++; $display("FAIL wr_ack: got %b required 1", bus.cpu_wr_ack); end
    n_cmp++;
    if (bus.wr_en !== 1'b1) begin n_err++; $display("FAIL wr_en: got %b required 1", bus.wr_en); end
    n_cmp++;
    if (bus.wr_addr !== 13'd5) begin n_err++; $display("FAIL wr_addr: got %0d required 5", bus.wr_addr); end
    n_cmp++;
    if (bus.wr_data !== 32'h41) begin n_err++; $display("FAIL wr_data: got %h required 41", bus.wr_data); end
    bus.cpu_wr_addr = 13'd4800;
    bus.cpu_wr_data = $urandom;
    cyc();
    n_cmp++;
    if (bus.cpu_wr_ack !== 1'b1) begin n_err++; $display("FAIL oor_ack: got %b required 1", bus.cpu_wr_ack); end
    n_cmp++;
    if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL oor_wr_en: got %b required 0", bus.wr_en); end
    bus.cpu_wr_req = 1'b0;
    cyc();
    n_cmp++;
    if (bus.cpu_wr_ack !== 1'b0) begin n_err++; $display("FAIL idle_ack: got %b required 0", bus.cpu_wr_ack); end
  endtask

  task automatic test_random_writes(input int n);
    for (int i = 0; i < n; i++) begin
      logic              req;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              exp_en;
      int                pick;
      req  = 1'($urandom_range(0, 3) != 0);
      pick = int'($urandom_range(0, 3));
      if (pick == 0)      a = ADDR_W'(DEPTH - 1);
      else if (pick == 1) a = ADDR_W'(DEPTH);
      else                a = ADDR_W'($urandom_range(0, 8191));
      d      = $urandom;
      exp_en = req && (32'(a) < DEPTH);
      bus.cpu_wr_req  = req;
      bus.cpu_wr_addr = a;
      bus.cpu_wr_data = d;
      cyc();
      n_cmp++;
      if (bus.cpu_wr_ack !== req) begin
        n_err++; $display("FAIL rnd_ack i%0d: got %b required %b", i, bus.cpu_wr_ack, req);
      end
      n_cmp++;
      if (bus.wr_en !== exp_en) begin
        n_err++; $display("FAIL rnd_wr_en i%0d addr %0d: got %b required %b", i, a, bus.wr_en, exp_en);
      end
      if (req) begin
        n_cmp++;
        if (bus.wr_addr !== a || bus.wr_data !== d) begin
          n_err++;
          $display("FAIL rnd_wr_bus i%0d: got %0d/%h required %0d/%h", i, bus.wr_addr, bus.wr_data, a, d);
        end
      end
    end
    bus.cpu_wr_req = 1'b0;
    cyc();
  endtask

  // One swap from request to completion; optional CPU write held from vblank and a
  // redundant swap_req during the vblank wait.
  task automatic do_swap(input bit clr, input int vb_delay, input bit cpu, input bit dup);
    int                done_lat    = 2 + int'(SETTLE_CYC) + (clr ? int'(DEPTH) : 0);
    int                clear_first = 2 + int'(SETTLE_CYC);
    logic [ADDR_W-1:0] caddr       = ADDR_W'($urandom_range(0, DEPTH + 100));
    logic [DATA_W-1:0] cdata       = $urandom;
    logic              old_front   = exp_front;
    logic              new_front   = ~exp_front;
    logic [15:0]       old_count   = exp_count;
    logic [15:0]       new_count   = exp_count + 16'd1;
    bus.swap_req      = 1'b1;
    bus.clear_on_swap = clr;
    cyc();
    n_cmp++;
    if (bus.swap_busy !== 1'b1) begin n_err++; $display("FAIL busy_accept: got %b required 1", bus.swap_busy); end
    for (int i = 0; i < vb_delay; i++) begin
      bus.swap_req      = dup && (i == 0);
      bus.clear_on_swap = ~clr;
      cyc();
      n_cmp++;
      if ({bus.swap_busy, bus.switch_buffer, bus.swap_done} !== 3'b100) begin
        n_err++;
        $display("FAIL wait_vb i%0d busy/switch/done: got %b required 100", i,
                 {bus.swap_busy, bus.switch_buffer, bus.swap_done});
      end
    end
    bus.swap_req      = 1'b0;
    bus.clear_on_swap = 1'b0;
    bus.vblank_start  = 1'b1;
    if (cpu) begin
      bus.cpu_wr_req  = 1'b1;
      bus.cpu_wr_addr = caddr;
      bus.cpu_wr_data = cdata;
    end
    for (int k = 1; k <= done_lat + 2; k++) begin
      logic clr_w, cpu_w, exp_ack, exp_f;
      logic [15:0] exp_c;
      cyc();
      bus.vblank_start = 1'b0;
      clr_w   = clr && (k >= clear_first) && (k < done_lat);
      exp_ack = cpu && (k == done_lat + 1);
      cpu_w   = exp_ack && (32'(caddr) < DEPTH);
      exp_f   = (k >= 2) ? new_front : old_front;
      exp_c   = (k >= 2) ? new_count : old_count;
      n_cmp++;
      if (bus.switch_buffer !== (k == 1)) begin
        n_err++; $display("FAIL switch k%0d: got %b required %b", k, bus.switch_buffer, (k == 1));
      end
      n_cmp++;
      if (bus.swap_done !== (k == done_lat)) begin
        n_err++; $display("FAIL done k%0d: got %b required %b", k, bus.swap_done, (k == done_lat));
      end
      n_cmp++;
      if (bus.swap_busy !== (k < done_lat)) begin
        n_err++; $display("FAIL busy k%0d: got %b required %b", k, bus.swap_busy, (k < done_lat));
      end
      n_cmp++;
      if (bus.cpu_wr_ack !== exp_ack) begin
        n_err++; $display("FAIL swap_ack k%0d: got %b required %b", k, bus.cpu_wr_ack, exp_ack);
      end
      n_cmp++;
      if (bus.wr_en !== (clr_w || cpu_w)) begin
        n_err++; $display("FAIL swap_wr_en k%0d: got %b required %b", k, bus.wr_en, (clr_w || cpu_w));
      end
      n_cmp++;
      if (bus.front_sel !== exp_f || bus.frame_count !== exp_c) begin
        n_err++;
        $display("FAIL front/count k%0d: got %b/%0d required %b/%0d", k, bus.front_sel,
                 bus.frame_count, exp_f, exp_c);
      end
      if (clr_w) begin
        n_cmp++;
        if (bus.wr_addr !== ADDR_W'(k - clear_first) || bus.wr_data !== CLEAR_WORD) begin
          n_err++;
          $display("FAIL clear_word k%0d: got %0d/%h required %0d/%h", k, bus.wr_addr,
                   bus.wr_data, k - clear_first, CLEAR_WORD);
        end
      end
      if (exp_ack) begin
        n_cmp++;
        if (bus.wr_addr !== caddr || bus.wr_data !== cdata) begin
          n_err++;
          $display("FAIL held_write k%0d: got %0d/%h required %0d/%h", k, bus.wr_addr,
                   bus.wr_data, caddr, cdata);
        end
        bus.cpu_wr_req = 1'b0;
      end
    end
    bus.cpu_wr_req = 1'b0;
    exp_front = new_front;
    exp_count = new_count;
  endtask

  task automatic test_swap_no_clear();
    do_swap(1'b0, 9, 1'b0, 1'b0);
  endtask

  task automatic test_swap_clear();
    do_swap(1'b1, 3, 1'b1, 1'b0);
  endtask

  task automatic test_collisions();
    do_swap(1'b0, 5, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_clear();
    bit found = 1'b0;
    bus.swap_req      = 1'b1;
    bus.clear_on_swap = 1'b1;
    cyc();
    bus.swap_req      = 1'b0;
    bus.clear_on_swap = 1'b0;
    cyc();
    bus.vblank_start = 1'b1;
    cyc();
    bus.vblank_start = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (bus.wr_en === 1'b1 && bus.wr_addr === 13'd100) found = 1'b1;
      else cyc();
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL mid_clear_reach: got none required addr 100"); end
    rst = 1'b1;
    cyc();
    n_cmp++;
    if (outs_vec() !== 68'd0) begin
      n_err++; $display("FAIL mid_clear_reset: got %h required 0", outs_vec());
    end
    rst = 1'b0;
    cyc();
    n_cmp++;
    if ({bus.buf_en, bus.swap_busy, bus.wr_en, bus.front_sel, bus.frame_count} !== 20'h80000) begin
      n_err++;
      $display("FAIL mid_clear_release: got %h required 80000",
               {bus.buf_en, bus.swap_busy, bus.wr_en, bus.front_sel, bus.frame_count});
    end
    exp_front = 1'b0;
    exp_count = 16'd0;
    do_swap(1'b0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      test_random_writes(8);
      do_swap(1'($urandom_range(0, 4) == 0), int'($urandom_range(1, 8)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write();
    test_random_writes(20);
    test_swap_no_clear();
    test_swap_clear();
    test_collisions();
    test_reset_mid_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_swap_ctrl.md
Name: frame_swap_ctrl

Overview:
- Sequences the character double buffer for the VGA text path.
- Accepts CPU character writes and forwards them to the current write (back) buffer.
- Accepts a "present frame" request and holds it until the next vertical-blank start, then issues a single-cycle buffer switch.
- Can refill the new back buffer with a blank character word, stalling CPU writes while the fill runs.

Parameters:
- ADDR_W, 13, buffer word address width.
- DATA_W, 32, buffer word width.
- DEPTH, 4800, valid words per buffer (80x60 characters); addresses 0..DEPTH-1.
- CLEAR_WORD, 32'h00000020, word written during a clear (ASCII space, default attributes).
- SETTLE_CYC, 2, idle cycles after a switch before any buffer write.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cpu_wr_req  in  1  CPU requests a write this cycle.
- cpu_wr_addr  in  ADDR_W  CPU write address.
- cpu_wr_data  in  DATA_W  CPU write data.
- cpu_wr_ack  out  1  registered; high one cycle when a request is consumed.
- swap_req  in  1  request a buffer swap at the next vblank.
- clear_on_swap  in  1  sampled with swap_req; clear the new back buffer after the swap.
- vblank_start  in  1  one-cycle pulse at the start of vertical blank, from the VGA timing block.
- swap_busy  out  1  high from swap acceptance until swap_done.
- swap_done  out  1  one-cycle pulse when the swap (and any clear) completes.
- front_sel  out  1  0 = buffer 1 displayed, 1 = buffer 2 displayed.
- buf_en  out  1  double-buffer enable.
- switch_buffer  out  1  one-cycle pulse to the double buffer.
- wr_addr  out  ADDR_W  back-buffer write address.
- wr_data  out  DATA_W  back-buffer write data.
- wr_en  out  1  back-buffer write strobe.
- frame_count  out  16  count of completed swaps; wraps 16'hFFFF to 0.

Behaviour:
- All outputs are registered. rst is sampled only on a rising clk edge.
- On reset:
  - state = IDLE.
  - These outputs clear to 0: cpu_wr_ack, swap_busy, swap_done, front_sel, buf_en, switch_buffer, wr_addr, wr_data, wr_en, frame_count.
  - Clear counter and latched clear flag clear to 0.
- buf_en goes to 1 on the first cycle after reset deasserts and stays at 1.
- Reset asserted mid-operation aborts immediately, including a clear in progress. Partial clear contents are not guaranteed.
- FSM states: IDLE, WAIT_VB, SWAP, SETTLE, CLEAR.
- CPU write path:
  - A request is accepted in IDLE or WAIT_VB, except in a WAIT_VB cycle where vblank_start=1.
  - On an accepted request, in the next cycle: wr_addr/wr_data take the CPU values, cpu_wr_ack=1, and wr_en=1 if cpu_wr_addr < DEPTH.
  - Out-of-range addresses are acked but dropped (wr_en=0).
  - Latency from request to wr_en is 1 cycle. One write per cycle, back-to-back supported.
  - In SWAP, SETTLE and CLEAR: cpu_wr_ack=0. The CPU holds cpu_wr_req and its address/data until acked.
- IDLE:
  - swap_req=1 moves to WAIT_VB, latches clear_on_swap, and sets swap_busy=1 next cycle.
  - If swap_req and cpu_wr_req are high together, both are accepted.
- WAIT_VB:
  - vblank_start=1 moves to SWAP.
  - swap_req is ignored in every state other than IDLE; swaps are not queued.
- SWAP (1 cycle):
  - switch_buffer=1 for exactly this cycle.
  - front_sel toggles and frame_count increments, both registered at exit.
  - Next state is SETTLE.
- SETTLE (SETTLE_CYC cycles): wr_en=0.
  - Exit to CLEAR if the clear flag is latched.
  - Otherwise exit to IDLE with swap_done=1 and swap_busy=0 on the same cycle.
- CLEAR:
  - wr_en=1 and wr_data=CLEAR_WORD; wr_addr steps 0,1,...,DEPTH-1, one per cycle, exactly DEPTH cycles.
  - After address DEPTH-1: go to IDLE with swap_done=1 and swap_busy=0, clear flag cleared, wr_en=0.
- vblank_start is ignored in every state except WAIT_VB.
- Total swap latency from vblank_start to swap_done:
  - no clear: 1 + SETTLE_CYC + 1 cycles.
  - with clear: 1 + SETTLE_CYC + DEPTH + 1 cycles.
- Unreachable state encodings return to IDLE with all strobes low.

Test Plan:
- Reset: hold rst=1 for 3 cycles while driving requests -> all outputs 0. First cycle after release: buf_en=1 and state IDLE.
- Write pass-through: cpu_wr_req with addr 13'd5, data 32'h41 -> next cycle wr_en=1, wr_addr=5, wr_data=32'h41, cpu_wr_ack=1. Addr 13'd4800 -> ack=1, wr_en=0.
- Swap without clear:
  - swap_req=1 (clear=0), vblank_start pulse 10 cycles later.
  - switch_buffer high exactly 1 cycle; front_sel goes 0->1; frame_count 0->1.
  - swap_done pulses 4 cycles after vblank_start; swap_busy high throughout.
- Swap with clear:
  - wr_en high for exactly 4800 consecutive cycles, addresses 0..4799, data 32'h20.
  - A CPU write held during the clear is acked only after swap_done.
- Collisions:
  - Second swap_req while in WAIT_VB -> exactly one switch_buffer pulse.
  - cpu_wr_req coincident with vblank_start -> not acked that cycle; acked after SETTLE.
- Reset mid-clear: rst at clear address 100 -> next cycle all outputs 0 and state IDLE. A subsequent swap behaves normally with frame_count starting from 0.
